// File: rtl/hs_upload_server.sv
// hs_upload_server: serves work-RAM bytes to HPS ioctl uploads while the game CPU is paused.
// Define HS_UPLOAD_CHECKSUM_EN to return a running XOR of served bytes at offset cfg_len.
module hs_upload_server #(
    parameter logic [7:0] UPLOAD_INDEX = 8'd4,
    parameter int         RAM_LATENCY  = 2,
    parameter int         SETTLE       = 4
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    input  logic [15:0] cfg_start,
    input  logic [15:0] cfg_len,
    output logic        pause_req,
    input  logic        pause_ack,
    output logic [15:0] ram_address,
    output logic        ram_access,
    input  logic [7:0]  ram_data
);
    typedef enum logic [2:0] {S_IDLE, S_PAUSE, S_SETTLE, S_READY, S_ACCESS, S_WAIT} state_t;
    localparam logic [3:0] SETTLE_END = 4'(SETTLE - 1);
    localparam logic [3:0] LAT_END    = 4'(RAM_LATENCY - 1);
    state_t      state, state_n;
    logic        act_q, rd_q, hi, hi_n;
    logic [15:0] off, off_n, addr_n;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  din_n, oor_byte;
    logic        wait_n, acc_n;
    logic        active, rise, rd_rise, in_range;
    assign active    = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign rise      = active && !act_q;
    assign rd_rise   = ioctl_rd && !rd_q;
    assign in_range  = !hi && (off < cfg_len);
    assign pause_req = (state != S_IDLE);
`ifdef HS_UPLOAD_CHECKSUM_EN
    logic [7:0] xsum, xsum_n;
    assign oor_byte = (!hi && off == cfg_len) ? xsum : 8'hFF;
`else
    assign oor_byte = 8'hFF;
`endif
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        off_n   = off;
        hi_n    = hi;
        wait_n  = ioctl_wait;
        din_n   = ioctl_din;
        addr_n  = ram_address;
        acc_n   = ram_access;
`ifdef HS_UPLOAD_CHECKSUM_EN
        xsum_n  = rise ? 8'h00 : xsum;
`endif
        if (rd_rise && active && !ioctl_wait) begin
            wait_n = 1'b1;
            off_n  = ioctl_addr[15:0];
            hi_n   = |ioctl_addr[24:16];
        end
        if (state >= S_SETTLE && !pause_ack) begin
            state_n = S_PAUSE;
            acc_n   = 1'b0;
        end else begin
            case (state)
                S_IDLE:   state_n = rise ? S_PAUSE : S_IDLE;
                S_PAUSE:  if (pause_ack) begin
                    state_n = S_SETTLE;
                    cnt_n   = 4'd0;
                end
                S_SETTLE: if (cnt == SETTLE_END) state_n = S_READY;
                          else cnt_n = cnt + 4'd1;
                S_READY:  if (ioctl_wait) begin
                    state_n = S_ACCESS;
                    acc_n   = in_range;
                    addr_n  = in_range ? cfg_start + off : ram_address;
                end
                S_ACCESS: if (ram_access) begin
                    state_n = S_WAIT;
                    cnt_n   = 4'd0;
                end else begin
                    state_n = S_READY;
                    wait_n  = 1'b0;
                    din_n   = oor_byte;
                end
                S_WAIT:   if (cnt == LAT_END) begin
                    state_n = S_READY;
                    wait_n  = 1'b0;
                    acc_n   = 1'b0;
                    din_n   = ram_data;
`ifdef HS_UPLOAD_CHECKSUM_EN
                    xsum_n  = xsum ^ ram_data;
`endif
                end else cnt_n = cnt + 4'd1;
                default:  state_n = S_IDLE;
            endcase
        end
        // losing the upload abandons everything except the last returned byte
        if (!active) begin
            state_n = S_IDLE;
            acc_n   = 1'b0;
            wait_n  = 1'b0;
        end
    end
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            act_q       <= 1'b0;
            rd_q        <= 1'b0;
            off         <= 16'd0;
            hi          <= 1'b0;
            cnt         <= 4'd0;
            ioctl_din   <= 8'd0;
            ioctl_wait  <= 1'b0;
            ram_address <= 16'd0;
            ram_access  <= 1'b0;
`ifdef HS_UPLOAD_CHECKSUM_EN
            xsum        <= 8'd0;
`endif
        end else begin
            state       <= state_n;
            act_q       <= active;
            rd_q        <= ioctl_rd;
            off         <= off_n;
            hi          <= hi_n;
            cnt         <= cnt_n;
            ioctl_din   <= din_n;
            ioctl_wait  <= wait_n;
            ram_address <= addr_n;
            ram_access  <= acc_n;
`ifdef HS_UPLOAD_CHECKSUM_EN
            xsum        <= xsum_n;
`endif
        end
    end
endmodule

// File: tb/tb_hs_upload_server.sv
// tb_hs_upload_server: directed vectors for hs_upload_server with a 2-cycle RAM model.
module tb_hs_upload_server;
    logic        clk_49m = 1'b0, reset = 1'b0;
    logic        ioctl_upload = 1'b0, ioctl_rd = 1'b0, pause_ack = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [15:0] cfg_start = 16'd0, cfg_len = 16'd0;
    logic [7:0]  ioctl_din, ram_data;
    logic        ioctl_wait, pause_req, ram_access;
    logic [15:0] ram_address;
    logic [7:0]  mem [0:65535];
    logic [7:0]  p1 = 8'd0, p2 = 8'd0;
    int          nvec = 0, nerr = 0;
    int          lat;
    logic        acc;
    logic [15:0] adr;
    logic [7:0]  exp_b [3] = '{8'hAA, 8'h55, 8'h0F};
    logic [15:0] exp_a [3] = '{16'h1C00, 16'h1C01, 16'h1C02};

    hs_upload_server dut (
        .clk_49m(clk_49m), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .pause_req(pause_req), .pause_ack(pause_ack),
        .ram_address(ram_address), .ram_access(ram_access), .ram_data(ram_data)
    );

    always #10 clk_49m = ~clk_49m;
    always @(posedge clk_49m) begin
        p1 <= mem[ram_address];
        p2 <= p1;
    end
    assign ram_data = p2;

    task automatic tick;
        @(posedge clk_49m);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_rd(input logic [24:0] a, output int l, output logic ac, output logic [15:0] ad);
        ioctl_addr = a;
        ioctl_rd = 1'b1;
        tick;
        ioctl_rd = 1'b0;
        check("wait_after_strobe", ioctl_wait, 1);
        l = 0;
        ac = 1'b0;
        ad = 16'd0;
        do begin
            tick;
            l++;
            if (ram_access) begin
                ac = 1'b1;
                ad = ram_address;
            end
        end while (ioctl_wait && l < 64);
    endtask

    task automatic start_upload(input logic [15:0] base);
        ioctl_upload = 1'b0;
        tick;
        pause_ack = 1'b0;
        cfg_start = base;
        cfg_len = 16'd3;
        ioctl_index = 8'd4;
        tick;
        ioctl_upload = 1'b1;
        tick;
        check("pause_req_up", pause_req, 1);
        repeat (2) tick;
        pause_ack = 1'b1;
        repeat (8) tick;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1C00] = 8'hAA;
        mem[16'h1C01] = 8'h55;
        mem[16'h1C02] = 8'h0F;
        mem[16'hFFFF] = 8'hC3;
        mem[16'h0001] = 8'h3C;
        repeat (3) tick;
        check("rst_din", ioctl_din, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_pause", pause_req, 0);
        check("rst_addr", ram_address, 0);
        check("rst_acc", ram_access, 0);
        reset = 1'b1;
        tick;
        // wrong index: completely ignored
        ioctl_index = 8'd1;
        ioctl_upload = 1'b1;
        repeat (3) tick;
        check("idx1_pause", pause_req, 0);
        ioctl_rd = 1'b1;
        tick;
        ioctl_rd = 1'b0;
        tick;
        check("idx1_wait", ioctl_wait, 0);
        check("idx1_acc", ram_access, 0);
        // main upload
        start_upload(16'h1C00);
        for (int i = 0; i < 3; i++) begin
            do_rd(25'(i), lat, acc, adr);
            check("rd_din", ioctl_din, exp_b[i]);
            check("rd_lat", lat, 4);
            check("rd_addr", adr, exp_a[i]);
            check("rd_acc", acc, 1);
            check("acc_released", ram_access, 0);
        end
        do_rd(25'd5, lat, acc, adr);
        check("oor_din", ioctl_din, 8'hFF);
        check("oor_lat", lat, 2);
        check("oor_acc", acc, 0);
        do_rd(25'd3, lat, acc, adr);
`ifdef HS_UPLOAD_CHECKSUM_EN
        check("len_din", ioctl_din, 8'hF0);
`else
        check("len_din", ioctl_din, 8'hFF);
`endif
        check("len_acc", acc, 0);
        do_rd(25'h0010001, lat, acc, adr);
        check("hi_din", ioctl_din, 8'hFF);
        check("hi_acc", acc, 0);
        // address wrap
        start_upload(16'hFFFF);
        do_rd(25'd2, lat, acc, adr);
        check("wrap_addr", adr, 16'h0001);
        check("wrap_din", ioctl_din, 8'h3C);
        check("wrap_lat", lat, 4);
        // strobe before pause_ack
        ioctl_upload = 1'b0;
        tick;
        check("drop_pause", pause_req, 0);
        pause_ack = 1'b0;
        cfg_start = 16'h1C00;
        tick;
        ioctl_upload = 1'b1;
        tick;
        check("early_pause", pause_req, 1);
        ioctl_addr = 25'd1;
        ioctl_rd = 1'b1;
        tick;
        ioctl_rd = 1'b0;
        repeat (3) tick;
        check("early_wait", ioctl_wait, 1);
        check("early_acc", ram_access, 0);
        pause_ack = 1'b1;
        lat = 0;
        do begin
            tick;
            lat++;
        end while (ioctl_wait && lat < 64);
        check("early_lat", lat, 9);
        check("early_din", ioctl_din, 8'h55);
        // abort during WAIT
        repeat (2) tick;
        ioctl_addr = 25'd0;
        ioctl_rd = 1'b1;
        tick;
        ioctl_rd = 1'b0;
        repeat (2) tick;
        check("abort_acc_before", ram_access, 1);
        ioctl_upload = 1'b0;
        tick;
        check("abort_acc", ram_access, 0);
        check("abort_pause", pause_req, 0);
        check("abort_wait", ioctl_wait, 0);
        check("abort_din", ioctl_din, 8'h55);
        // asynchronous reset mid-access
        start_upload(16'h1C00);
        ioctl_addr = 25'd2;
        ioctl_rd = 1'b1;
        tick;
        ioctl_rd = 1'b0;
        tick;
        check("rstmid_acc_before", ram_access, 1);
        reset = 1'b0;
        #2;
        check("rstmid_acc", ram_access, 0);
        check("rstmid_pause", pause_req, 0);
        check("rstmid_wait", ioctl_wait, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
